// File: rtl/result_uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : result_uart_tx_if
// Purpose  : Decoder-result to UART-transmitter bundle (strobe, data, line and status).
// Revision : 1.0
// ============================================================================
interface result_uart_tx_if;
    logic        result_valid;
    logic [11:0] result_data;
    logic        uart_tx;
    logic        tx_busy;
    logic        fifo_full;
    logic        overflow;

    modport master (
        output result_valid,
        output result_data,
        input  uart_tx,
        input  tx_busy,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  result_valid,
        input  result_data,
        output uart_tx,
        output tx_busy,
        output fifo_full,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/result_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : result_uart_tx
// Purpose  : Buffers 12-bit decoder results and sends each as two 8N1 bytes.
// Revision : 1.0
// ============================================================================
module result_uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       sys_rst,
    result_uart_tx_if.slave bus
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int c_BAUD_W = (c_CLKS_PER_BIT < 2) ? 1 : $clog2(c_CLKS_PER_BIT);
    localparam int c_PTR_W  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);

    generate
        if (c_CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("result_uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("result_uart_tx: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // FIFO storage and bookkeeping
    logic [11:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_next;
    logic                r_full;
    logic                r_overflow;
    logic                w_push;
    logic                w_pop;
    logic                w_non_empty;
    logic [11:0]         w_head;

    // Serialiser
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic                r_byte_sel;
    logic [7:0]          r_shift;
    logic [7:0]          r_low_byte;
    logic                r_tx;
    logic                w_bit_done;
    logic                w_tx_next;

    // The full flag is the pre-edge value, so a same-cycle pop never admits a write.
    assign w_push      = bus.result_valid & ~r_full;
    assign w_non_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_bit_done  = (r_baud_cnt == c_BAUD_LAST);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.result_data;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
            if (bus.result_valid && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Line level is computed from the current state and registered, so the pin lags the state by one cycle.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_non_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_bit_done) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_state_next = r_byte_sel ? S_IDLE : S_START;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_sel <= 1'b0;
            r_shift    <= '0;
            r_low_byte <= '0;
        end else begin
            r_tx <= w_tx_next;
            if (r_state == S_IDLE) begin
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
                if (w_pop) begin
                    r_shift    <= {4'hA, w_head[11:8]};
                    r_low_byte <= w_head[7:0];
                    r_byte_sel <= 1'b0;
                end
            end else if (w_bit_done) begin
                r_baud_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
                // High byte done: reload the low byte and go straight back to START.
                if ((r_state == S_STOP) && !r_byte_sel) begin
                    r_byte_sel <= 1'b1;
                    r_shift    <= r_low_byte;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
            end
        end
    end

    assign bus.uart_tx   = r_tx;
    assign bus.tx_busy   = (r_state != S_IDLE) | w_non_empty;
    assign bus.fifo_full = r_full;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire
